// File: rtl/sdram_fifo_ctrl.sv
// User-side SDRAM port: write FIFO drained in bursts, read FIFO filled
// by prefetch bursts, addresses cycling through [MIN_ADDR, MAX_ADDR).
module sdram_fifo_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 24,
    parameter int FIFO_DEPTH = 256,
    parameter int BURST_LEN  = 8,
    parameter int MIN_ADDR   = 0,
    parameter int MAX_ADDR   = 128
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic              read_valid,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    output logic              sdram_wr_req,
    input  logic              sdram_wr_ack,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [DATA_W-1:0] sdram_din,
    output logic              sdram_rd_req,
    input  logic              sdram_rd_ack,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    input  logic [DATA_W-1:0] sdram_dout
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [PW:0]       DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]       BURST_C = (PW+1)'(BURST_LEN);
    localparam logic [BW-1:0]     LAST_C  = BW'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] MIN_A   = ADDR_W'(MIN_ADDR);
    localparam logic [ADDR_W-1:0] MAX_A   = ADDR_W'(MAX_ADDR);
    localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_BURST = 2'd1;
    localparam logic [1:0] RD_BURST = 2'd2;

    logic              init_meta;
    logic              init_sync;

    logic [DATA_W-1:0] wmem [FIFO_DEPTH];
    logic [PW-1:0]     wwp;
    logic [PW-1:0]     wrp;
    logic [PW:0]       wcnt;

    logic [DATA_W-1:0] rmem [FIFO_DEPTH];
    logic [PW-1:0]     rwp;
    logic [PW-1:0]     rrp;
    logic [PW:0]       rcnt;

    logic [1:0]        state;
    logic [BW-1:0]     bcnt;

    logic              wr_push;
    logic              wr_pop;
    logic              rd_push;
    logic              rd_pop;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] s;
        s = a + BURST_A;
        return (s >= MAX_A) ? MIN_A : s;
    endfunction

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            init_meta <= 1'b0;
            init_sync <= 1'b0;
        end else begin
            init_meta <= sdram_init_done;
            init_sync <= init_meta;
        end
    end

    // Flags come from the pre-pop count, so a full FIFO refuses a push
    // even when a pop happens in the same cycle.
    assign wr_full  = (wcnt == DEPTH_C);
    assign rd_empty = (rcnt == '0);

    assign wr_push = wr_en & ~wr_full;
    assign wr_pop  = (state == WR_BURST) & sdram_wr_ack & (wcnt != '0);
    assign rd_push = (state == RD_BURST) & sdram_rd_ack & (rcnt != DEPTH_C);
    assign rd_pop  = rd_en & ~rd_empty;

    assign sdram_din = (wcnt == '0) ? '0 : wmem[wrp];

    always_ff @(posedge clk_50m) begin
        if (wr_push)
            wmem[wwp] <= wr_data;
        if (rd_push)
            rmem[rwp] <= sdram_dout;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wwp  <= '0;
            wrp  <= '0;
            wcnt <= '0;
        end else begin
            if (wr_push)
                wwp <= wwp + 1'b1;
            if (wr_pop)
                wrp <= wrp + 1'b1;
            if (wr_push && !wr_pop)
                wcnt <= wcnt + 1'b1;
            else if (!wr_push && wr_pop)
                wcnt <= wcnt - 1'b1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rwp     <= '0;
            rrp     <= '0;
            rcnt    <= '0;
            rd_data <= '0;
        end else begin
            if (rd_push)
                rwp <= rwp + 1'b1;
            if (rd_pop) begin
                rrp     <= rrp + 1'b1;
                rd_data <= rmem[rrp];
            end
            if (rd_push && !rd_pop)
                rcnt <= rcnt + 1'b1;
            else if (!rd_push && rd_pop)
                rcnt <= rcnt - 1'b1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bcnt          <= '0;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            sdram_wr_addr <= MIN_A;
            sdram_rd_addr <= MIN_A;
        end else begin
            case (state)
                IDLE: begin
                    bcnt <= '0;
                    if (init_sync) begin
                        if (wcnt >= BURST_C) begin
                            state        <= WR_BURST;
                            sdram_wr_req <= 1'b1;
                        end else if (read_valid && (DEPTH_C - rcnt) >= BURST_C) begin
                            state        <= RD_BURST;
                            sdram_rd_req <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (sdram_wr_ack) begin
                        if (bcnt == LAST_C) begin
                            state         <= IDLE;
                            bcnt          <= '0;
                            sdram_wr_req  <= 1'b0;
                            sdram_wr_addr <= next_addr(sdram_wr_addr);
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                RD_BURST: begin
                    if (sdram_rd_ack) begin
                        if (bcnt == LAST_C) begin
                            state         <= IDLE;
                            bcnt          <= '0;
                            sdram_rd_req  <= 1'b0;
                            sdram_rd_addr <= next_addr(sdram_rd_addr);
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bcnt         <= '0;
                    sdram_wr_req <= 1'b0;
                    sdram_rd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Directed bench for sdram_fifo_ctrl with a behavioural SDRAM that acks
// while its enable is set and returns addr+index+1 on reads.
module tb_sdram_fifo_ctrl;

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdram_init_done = 1'b0;
    logic        read_valid = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_full;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_empty;
    logic        sdram_wr_req;
    logic        sdram_wr_ack;
    logic [23:0] sdram_wr_addr;
    logic [15:0] sdram_din;
    logic        sdram_rd_req;
    logic        sdram_rd_ack;
    logic [23:0] sdram_rd_addr;
    logic [15:0] sdram_dout;

    logic        wr_ack_on = 1'b0;
    logic        rd_ack_on = 1'b0;
    logic [7:0]  rd_idx = '0;

    int checks = 0;
    int failures = 0;

    always #10 clk_50m = ~clk_50m;

    assign sdram_wr_ack = wr_ack_on & sdram_wr_req;
    assign sdram_rd_ack = rd_ack_on & sdram_rd_req;
    assign sdram_dout   = 16'(sdram_rd_addr + 24'(rd_idx) + 24'd1);

    always @(posedge clk_50m) begin
        if (!sdram_rd_req)
            rd_idx <= '0;
        else if (sdram_rd_ack)
            rd_idx <= rd_idx + 8'd1;
    end

    sdram_fifo_ctrl dut (
        .clk_50m         (clk_50m),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .read_valid      (read_valid),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .wr_full         (wr_full),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_empty        (rd_empty),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_din       (sdram_din),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_dout      (sdram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk_50m);
        wr_en   = 1'b0;
    endtask

    task automatic wait_wr(input logic v, input int bound, input string tag);
        int n = 0;
        while (sdram_wr_req !== v && n < bound) begin
            @(negedge clk_50m);
            n++;
        end
        chk(tag, 32'(sdram_wr_req), 32'(v));
    endtask

    task automatic wait_rd(input logic v, input int bound, input string tag);
        int n = 0;
        while (sdram_rd_req !== v && n < bound) begin
            @(negedge clk_50m);
            n++;
        end
        chk(tag, 32'(sdram_rd_req), 32'(v));
    endtask

    initial begin
        // T1 reset values
        repeat (3) @(negedge clk_50m);
        chk("t1_wr_full", 32'(wr_full), 32'd0);
        chk("t1_rd_empty", 32'(rd_empty), 32'd1);
        chk("t1_rd_data", 32'(rd_data), 32'd0);
        chk("t1_wr_req", 32'(sdram_wr_req), 32'd0);
        chk("t1_rd_req", 32'(sdram_rd_req), 32'd0);
        chk("t1_din", 32'(sdram_din), 32'd0);
        chk("t1_wr_addr", 32'(sdram_wr_addr), 32'd0);
        chk("t1_rd_addr", 32'(sdram_rd_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_50m);

        // T2 first write burst
        sdram_init_done = 1'b1;
        wr_ack_on = 1'b1;
        for (int i = 1; i <= 8; i++)
            push(16'(i));
        wait_wr(1'b1, 3, "t2_req_rise");
        for (int k = 1; k <= 8; k++) begin
            chk("t2_req_hold", 32'(sdram_wr_req), 32'd1);
            chk("t2_din", 32'(sdram_din), 32'(k));
            @(negedge clk_50m);
        end
        chk("t2_req_fall", 32'(sdram_wr_req), 32'd0);
        chk("t2_wr_addr", 32'(sdram_wr_addr), 32'd8);

        // T3 address wrap over the 128-word region
        for (int b = 0; b < 15; b++) begin
            for (int j = 0; j < 8; j++)
                push(16'(100 + b * 8 + j));
            wait_wr(1'b1, 5, "t3_req_rise");
            wait_wr(1'b0, 20, "t3_req_fall");
            chk("t3_wr_addr", 32'(sdram_wr_addr), 32'(((b + 2) * 8) % 128));
        end

        // T4 read prefetch and user reads
        rd_ack_on = 1'b1;
        read_valid = 1'b1;
        wait_rd(1'b1, 5, "t4_req_rise");
        read_valid = 1'b0;
        wait_rd(1'b0, 20, "t4_req_fall");
        chk("t4_rd_empty", 32'(rd_empty), 32'd0);
        chk("t4_rd_addr", 32'(sdram_rd_addr), 32'd8);
        rd_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_50m);
            chk("t4_rd_data", 32'(rd_data), 32'(k));
        end
        chk("t4_empty_after", 32'(rd_empty), 32'd1);
        @(negedge clk_50m);
        chk("t4_hold_empty", 32'(rd_data), 32'd8);
        rd_en = 1'b0;

        // T5 write wins over read when both are ready together
        sdram_init_done = 1'b0;
        repeat (3) @(negedge clk_50m);
        for (int j = 0; j < 8; j++)
            push(16'(16'h0500 + j));
        read_valid = 1'b1;
        sdram_init_done = 1'b1;
        wait_wr(1'b1, 6, "t5_wr_first");
        chk("t5_rd_idle", 32'(sdram_rd_req), 32'd0);
        wait_wr(1'b0, 20, "t5_wr_done");
        chk("t5_gap", 32'(sdram_rd_req), 32'd0);
        @(negedge clk_50m);
        chk("t5_rd_next", 32'(sdram_rd_req), 32'd1);
        read_valid = 1'b0;
        wait_rd(1'b0, 20, "t5_rd_done");
        chk("t5_wr_addr", 32'(sdram_wr_addr), 32'd8);
        chk("t5_rd_addr", 32'(sdram_rd_addr), 32'd16);

        // T6 fill to full, drop the 257th word, then drain
        wr_ack_on = 1'b0;
        for (int i = 1; i <= 255; i++)
            push(16'(i));
        chk("t6_not_full", 32'(wr_full), 32'd0);
        push(16'd256);
        chk("t6_full", 32'(wr_full), 32'd1);
        push(16'hFFFF);
        chk("t6_still_full", 32'(wr_full), 32'd1);
        chk("t6_head", 32'(sdram_din), 32'd1);
        wr_ack_on = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            for (int n = 0; n < 4 && sdram_wr_req !== 1'b1; n++)
                @(negedge clk_50m);
            chk("t6_drain", 32'(sdram_din), 32'(i));
            @(negedge clk_50m);
        end
        repeat (4) @(negedge clk_50m);
        chk("t6_no_extra", 32'(sdram_wr_req), 32'd0);
        chk("t6_wr_addr", 32'(sdram_wr_addr), 32'd8);

        // T6 reset in the middle of a burst
        wr_ack_on = 1'b0;
        for (int j = 0; j < 8; j++)
            push(16'(16'h0A00 + j));
        wait_wr(1'b1, 5, "t6_burst_up");
        chk("t6_rd_loaded", 32'(rd_empty), 32'd0);
        wr_ack_on = 1'b1;
        repeat (3) @(negedge clk_50m);
        #2 rst_n = 1'b0;
        #1;
        chk("t6r_wr_req", 32'(sdram_wr_req), 32'd0);
        chk("t6r_rd_req", 32'(sdram_rd_req), 32'd0);
        chk("t6r_rd_empty", 32'(rd_empty), 32'd1);
        chk("t6r_wr_full", 32'(wr_full), 32'd0);
        chk("t6r_din", 32'(sdram_din), 32'd0);
        chk("t6r_rd_data", 32'(rd_data), 32'd0);
        chk("t6r_wr_addr", 32'(sdram_wr_addr), 32'd0);
        chk("t6r_rd_addr", 32'(sdram_rd_addr), 32'd0);
        wr_ack_on = 1'b0;
        @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50m);
        chk("t6r_stay_idle", 32'(sdram_wr_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
